pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the halt_i hold input of every
//  pipeline register (IFID/IDEX/EXMEM/MEMWB) and the PC/IFID write enables. Inserts load-use bubbles
//  into IDEX and flushes IFID on taken branches. Freezes the whole pipe while the dcache reports a miss,
//  with a watchdog for a stuck miss.
// PARAMETERS
//  LU_BUBBLES   1    bubbles inserted per load-use hazard (1..7)
//  BR_PENALTY   1    cycles IFID is flushed after a taken branch (1..7)
//  MEM_TIMEOUT  255  max consecutive mem_stall_i cycles before timeout_o sets (1..65535)
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   asynchronous, active-low reset
//  idex_memread_i  in   1   IDEX M_o read bit (instruction in EX is a load)
//  idex_rt_i       in   5   IDEX rt_o (load destination)
//  ifid_rs_i       in   5   rs of instruction in ID
//  ifid_rt_i       in   5   rt of instruction in ID
//  branch_taken_i  in   1   branch resolved taken in ID this cycle
//  mem_stall_i     in   1   dcache busy/miss; pipeline must hold
//  halt_o          out  1   to halt_i of all pipeline registers
//  pc_write_o      out  1   PC update enable
//  ifid_write_o    out  1   IFID load enable
//  ifid_flush_o    out  1   IFID clears to NOP
//  idex_bubble_o   out  1   zero WB/M/EX fields entering IDEX
//  state_o         out  2   current FSM state (debug)
//  timeout_o       out  1   sticky: miss exceeded MEM_TIMEOUT
//  stall_cycles_o  out  32  perf: cycles with halt_o=1 (see CONFIGURATION)
//  bubble_count_o  out  32  perf: bubbles inserted (see CONFIGURATION)
// BEHAVIOUR
//  - hazard = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
//  - FSM states: RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3. 3-bit down-counter cnt. Sticky timeout_o.
//    16-bit miss counter mcnt. ret_state register.
//  - Control outputs are combinational from state and inputs, zero latency. State and counters update
//    on the clock edge.
//  - Priority in any state: mem_stall_i > hazard > branch_taken_i.
//  - mem_stall_i=1: halt_o=1, pc_write_o=0, ifid_write_o=0, flush=0, bubble=0.
//    - Next state is MEM_WAIT. ret_state is captured only on entry from a non-MEM_WAIT state.
//    - cnt and all other state hold; nothing advances.
//  - MEM_WAIT with mem_stall_i=0: behave as ret_state for outputs this cycle. Next state = ret_state.
//  - RUN, hazard: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
//    - LU_BUBBLES==1: stay in RUN.
//    - Otherwise: go to LU_STALL with cnt=LU_BUBBLES-1.
//  - LU_STALL: same outputs as RUN-hazard. cnt decrements each cycle; at cnt==1, next state = RUN.
//  - RUN, branch_taken_i and no hazard: ifid_flush_o=1, pc_write_o=1.
//    - BR_PENALTY==1: stay in RUN.
//    - Otherwise: go to BR_FLUSH with cnt=BR_PENALTY-1.
//  - BR_FLUSH: ifid_flush_o=1. cnt decrements; at cnt==1, next state = RUN. branch_taken_i ignored here.
//  - Simultaneous hazard + branch: stall only. The branch re-resolves next cycle with forwarded data.
//  - RUN, no events: halt_o=0, pc_write_o=1, ifid_write_o=1, flush=0, bubble=0.
//  - mcnt: increments while mem_stall_i=1 and saturates at 65535; clears when mem_stall_i=0.
//    timeout_o sets when mcnt reaches MEM_TIMEOUT and stays set until reset. Pipeline keeps waiting.
//  - Reset (async assert, sync-safe release): state=RUN, cnt=0, mcnt=0, ret_state=RUN, timeout_o=0,
//    perf counters=0.
//    - While rst_i=0: halt_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0,
//      state_o=0, regardless of inputs.
//    - Reset mid-stall or mid-flush abandons the sequence.
//  - state_o = state register.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: perf counters are enabled.
//    - stall_cycles_o increments on each cycle with halt_o=1.
//    - bubble_count_o increments on each cycle with idex_bubble_o=1.
//    - Both are 32-bit and wrap 0xFFFFFFFF->0.
//  - HAZARD_PERF_EN undefined: no counter flops; both ports tied to 0.
// TESTING
//  - Reset with branch_taken_i=1, mem_stall_i=1 -> outputs at RUN values, state_o=0, timeout_o=0.
//  - Load rt=5 in EX, ID rs=5, LU_BUBBLES=2 -> bubble=1 and pc_write=0 for exactly 2 cycles, then
//    RUN; rt=0 -> no stall.
//  - branch_taken_i 1 cycle, BR_PENALTY=3 -> ifid_flush_o=1 for 3 cycles; pc_write_o=1 throughout.
//  - mem_stall_i raised on 2nd bubble of LU stall for 4 cycles -> halt_o=1 for 4 cycles, then 1 more
//    bubble; total bubbles=2.
//  - MEM_TIMEOUT=8, mem_stall_i held 10 cycles -> timeout_o rises on the edge where mcnt reaches 8,
//    stays 1 after stall drops.
//  - HAZARD_PERF_EN: 4 halt cycles + 2 bubbles -> stall_cycles_o=4, bubble_count_o=2;
//    without the macro both read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Holds
//            every pipeline register while the dcache misses. Inserts
//            load-use bubbles into IDEX. Flushes IFID after a taken branch.
//            A watchdog flags a dcache miss that never completes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LU_BUBBLES   bubbles inserted per load-use hazard            (1..7)
//   BR_PENALTY   cycles IFID is flushed after a taken branch     (1..7)
//   MEM_TIMEOUT  consecutive mem_stall_i cycles before timeout_o (1..65535)
// Ports
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous reset, active low
//   idex_memread_i  in   instruction in EX is a load
//   idex_rt_i       in   load destination register (5b)
//   ifid_rs_i       in   rs of instruction in ID (5b)
//   ifid_rt_i       in   rt of instruction in ID (5b)
//   branch_taken_i  in   branch resolved taken in ID this cycle
//   mem_stall_i     in   dcache busy/miss; whole pipe must hold
//   halt_o          out  hold input of every pipeline register
//   pc_write_o      out  PC update enable
//   ifid_write_o    out  IFID load enable
//   ifid_flush_o    out  IFID clears to NOP
//   idex_bubble_o   out  zero control fields entering IDEX
//   state_o         out  current FSM state (debug, 2b)
//   timeout_o       out  sticky: a miss lasted MEM_TIMEOUT cycles
//   stall_cycles_o  out  perf: cycles with halt_o=1 (32b)
//   bubble_count_o  out  perf: cycles with idex_bubble_o=1 (32b)
// Configuration
//   HAZARD_PERF_EN  when defined the two perf counters exist; otherwise both
//                   perf ports are tied to zero and no counter flops exist.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        mem_stall_i,
  output logic        halt_o,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic [1:0]  state_o,
  output logic        timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] bubble_count_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0]  c_LU_LOAD     = 3'(LU_BUBBLES - 1);
  localparam logic [2:0]  c_BR_LOAD     = 3'(BR_PENALTY - 1);
  localparam logic [15:0] c_MEM_TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [15:0] c_MCNT_MAX    = 16'hFFFF;

  state_t      r_state;
  state_t      r_ret_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_mcnt;
  logic        r_timeout;

  state_t      w_act_state;
  state_t      w_next_state;
  state_t      w_next_ret;
  logic [2:0]  w_next_cnt;
  logic [15:0] w_mcnt_next;
  logic        w_hazard;
  logic        w_halt;
  logic        w_pc_write;
  logic        w_ifid_write;
  logic        w_flush;
  logic        w_bubble;

  // --------------------------------------------------------------------------
  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hazard = idex_memread_i & (idex_rt_i != 5'd0) &
               ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode.
  // On the cycle a miss clears, MEM_WAIT acts exactly as the state it
  // interrupted (outputs, counter and transition), so a sequence resumes with
  // no extra cycle and never repeats the cycle that was frozen.
  // --------------------------------------------------------------------------
  always_comb begin
    w_act_state  = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;
    w_next_state = w_act_state;
    w_next_ret   = r_ret_state;
    w_next_cnt   = r_cnt;
    w_halt       = 1'b0;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;

    if (mem_stall_i) begin
      w_halt       = 1'b1;
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_next_state = ST_MEM_WAIT;
      // Only the first cycle of a miss remembers where to return to.
      if (r_state != ST_MEM_WAIT) begin
        w_next_ret = r_state;
      end
    end else begin
      case (w_act_state)
        ST_RUN: begin
          if (w_hazard) begin
            // A simultaneous taken branch is dropped: it re-resolves once the
            // load data can be forwarded.
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
            if (LU_BUBBLES > 1) begin
              w_next_state = ST_LU_STALL;
              w_next_cnt   = c_LU_LOAD;
            end
          end else if (branch_taken_i) begin
            w_flush = 1'b1;
            if (BR_PENALTY > 1) begin
              w_next_state = ST_BR_FLUSH;
              w_next_cnt   = c_BR_LOAD;
            end
          end
        end

        ST_LU_STALL: begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
          w_next_cnt   = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_next_state = ST_RUN;
          end
        end

        ST_BR_FLUSH: begin
          // ID holds a squashed instruction, so branch and hazard inputs are
          // not acted on until the flush window has elapsed.
          w_flush    = 1'b1;
          w_next_cnt = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_next_state = ST_RUN;
          end
        end

        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive. Reset forces the free-running RUN values regardless of the
  // inputs so downstream registers see a clean pipe during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    halt_o        = rst_i & w_halt;
    pc_write_o    = ~rst_i | w_pc_write;
    ifid_write_o  = ~rst_i | w_ifid_write;
    ifid_flush_o  = rst_i & w_flush;
    idex_bubble_o = rst_i & w_bubble;
    state_o       = r_state;
    timeout_o     = r_timeout;
  end

  // --------------------------------------------------------------------------
  // FSM registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_cnt       <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_next_ret;
      r_cnt       <= w_next_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Miss watchdog: saturating run-length of mem_stall_i, sticky timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    if (!mem_stall_i) begin
      w_mcnt_next = 16'd0;
    end else if (r_mcnt == c_MCNT_MAX) begin
      w_mcnt_next = r_mcnt;
    end else begin
      w_mcnt_next = r_mcnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mcnt    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_mcnt <= w_mcnt_next;
      if (mem_stall_i && (w_mcnt_next >= c_MEM_TIMEOUT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional performance counters (wrap naturally at 32 bits).
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cycles <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (halt_o) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (idex_bubble_o) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign bubble_count_o = r_bubble_count;
`else
  assign stall_cycles_o = 32'd0;
  assign bubble_count_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. A reference model
//            tracks pending bubbles / flush cycles and the miss run length,
//            and every cycle's outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int LU = 2;
  localparam int BR = 3;
  localparam int MT = 8;

  // {halt, pc_write, ifid_write, flush, bubble}
  localparam logic [4:0] c_CTL_HALT  = 5'b10000;
  localparam logic [4:0] c_CTL_BUB   = 5'b00001;
  localparam logic [4:0] c_CTL_FLUSH = 5'b01110;
  localparam logic [4:0] c_CTL_IDLE  = 5'b01100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = 5'd0;
  logic [4:0]  ifid_rs_i = 5'd0;
  logic [4:0]  ifid_rt_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic        halt_o;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic [1:0]  state_o;
  logic        timeout_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] bubble_count_o;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(
    .LU_BUBBLES  (LU),
    .BR_PENALTY  (BR),
    .MEM_TIMEOUT (MT)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_stall_i    (mem_stall_i),
    .halt_o         (halt_o),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o),
    .stall_cycles_o (stall_cycles_o),
    .bubble_count_o (bubble_count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: work still owed after the current cycle.
  int m_lu_left;
  int m_br_left;
  int m_stalled_last;
  int m_mrun;
  int m_timeout;
  int m_halts;
  int m_bubbles;

  // Observed-event tallies for directed scenarios.
  int seen_bub;
  int seen_halt;
  int seen_flush;
  int seen_pc_off;

  task automatic model_clear();
    m_lu_left = 0; m_br_left = 0; m_stalled_last = 0;
    m_mrun = 0; m_timeout = 0; m_halts = 0; m_bubbles = 0;
  endtask

  task automatic clear_seen();
    seen_bub = 0; seen_halt = 0; seen_flush = 0; seen_pc_off = 0;
  endtask

  function automatic logic [31:0] perf_exp(input int v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v * 0);
`endif
  endfunction

  // Called at posedge+1: drive, check at the falling edge, advance model.
  task automatic step(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] irt, input logic br, input logic ms);
    int kind;  // 0 halt, 1 bubble cont, 2 flush cont, 3 new bubble, 4 new flush, 5 idle
    bit hz;
    logic [4:0] exp_ctl;
    logic [1:0] exp_state;
    idex_memread_i = mr; idex_rt_i = rt; ifid_rs_i = rs; ifid_rt_i = irt;
    branch_taken_i = br; mem_stall_i = ms;
    hz = mr && (rt != 0) && ((rt == rs) || (rt == irt));
    if (ms)                 kind = 0;
    else if (m_lu_left > 0) kind = 1;
    else if (m_br_left > 0) kind = 2;
    else if (hz)            kind = 3;
    else if (br)            kind = 4;
    else                    kind = 5;
    case (kind)
      0:       exp_ctl = c_CTL_HALT;
      1, 3:    exp_ctl = c_CTL_BUB;
      2, 4:    exp_ctl = c_CTL_FLUSH;
      default: exp_ctl = c_CTL_IDLE;
    endcase
    if (m_stalled_last != 0) exp_state = 2'd3;
    else if (m_lu_left > 0)  exp_state = 2'd1;
    else if (m_br_left > 0)  exp_state = 2'd2;
    else                     exp_state = 2'd0;
    #4;
    chk("ctl", {27'd0, halt_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o},
        {27'd0, exp_ctl});
    chk("state", {30'd0, state_o}, {30'd0, exp_state});
    chk("timeout", {31'd0, timeout_o}, 32'(m_timeout));
    chk("stall_cycles", stall_cycles_o, perf_exp(m_halts));
    chk("bubble_count", bubble_count_o, perf_exp(m_bubbles));
    seen_bub    += int'(idex_bubble_o);
    seen_halt   += int'(halt_o);
    seen_flush  += int'(ifid_flush_o);
    seen_pc_off += int'(!pc_write_o);
    @(posedge clk_i);
    if (ms) begin
      m_mrun = (m_mrun < 65535) ? m_mrun + 1 : 65535;
      if (m_mrun >= MT) m_timeout = 1;
      m_stalled_last = 1;
      m_halts++;
    end else begin
      m_mrun = 0;
      m_stalled_last = 0;
      case (kind)
        1: begin m_lu_left--; m_bubbles++; end
        2: m_br_left--;
        3: begin m_lu_left = LU - 1; m_bubbles++; end
        4: m_br_left = BR - 1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Reset with hostile inputs; outputs must sit at RUN values throughout.
  task automatic do_reset();
    rst_i = 1'b0;
    idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rs_i = 5'd5; ifid_rt_i = 5'd5;
    branch_taken_i = 1'b1; mem_stall_i = 1'b1;
    #4;
    chk("rst_ctl", {27'd0, halt_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o},
        {27'd0, c_CTL_IDLE});
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    chk("rst_perf", stall_cycles_o | bubble_count_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    idex_memread_i = 1'b0; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
    branch_taken_i = 1'b0; mem_stall_i = 1'b0;
    model_clear();
  endtask

  initial begin
    int ms_left;
    bit rmr, rbr, rms;
    logic [4:0] rrt, rrs, rirt;
    model_clear();
    clear_seen();
    @(posedge clk_i);
    #1;
    do_reset();

    // Load-use hazard: exactly LU bubbles with PC frozen, then RUN.
    clear_seen();
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    idle(4);
    chk("lu_bubbles", 32'(seen_bub), 32'(LU));
    chk("lu_pc_off", 32'(seen_pc_off), 32'(LU));

    // Destination r0 never stalls; rt-operand match does.
    clear_seen();
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("r0_no_stall", 32'(seen_bub), 32'd0);
    step(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0);  // hazard + branch -> stall only
    idle(4);
    chk("rt_match_bub", 32'(seen_bub), 32'(LU));
    chk("hz_br_noflush", 32'(seen_flush), 32'd0);

    // Taken branch: flush for BR cycles, PC keeps moving.
    clear_seen();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);  // ignored inside flush window
    idle(4);
    chk("br_flush", 32'(seen_flush), 32'(BR));
    chk("br_pc_on", 32'(seen_pc_off), 32'd0);

    // Miss on the 2nd bubble: 4 halt cycles, then one more bubble.
    do_reset();
    clear_seen();
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(3);
    chk("miss_halts", 32'(seen_halt), 32'd4);
    chk("miss_bubbles", 32'(seen_bub), 32'd2);
    chk("perf_stall", stall_cycles_o, perf_exp(4));
    chk("perf_bubble", bubble_count_o, perf_exp(2));

    // Watchdog: 10-cycle miss trips timeout, which stays set.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(2);
    chk("timeout_hold", {31'd0, timeout_o}, 32'd1);

    // Reset in the middle of a flush abandons it.
    do_reset();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    do_reset();
    clear_seen();
    idle(2);
    chk("rst_abandon", 32'(seen_flush), 32'd0);

    // Randomized traffic with bursty misses and occasional resets.
    ms_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      rmr  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rrt = 5'd0;
        1:       rrt = 5'd5;
        default: rrt = 5'd6;
      endcase
      rrs  = 5'($urandom_range(5, 7));
      rirt = 5'($urandom_range(5, 7));
      rbr  = ($urandom_range(0, 3) == 0);
      if (ms_left > 0) begin
        rms = 1'b1;
        ms_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        rms = 1'b1;
        ms_left = $urandom_range(0, 10);
      end else begin
        rms = 1'b0;
      end
      step(rmr, rrt, rrs, rirt, rbr, rms);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
